counter_seq: RTL and testbench

Command-driven sequencer that sits directly upstream of the team's loadable up-counter and generates its `cen`/`wen`/`dat` control. Accepts LOAD, RUN, ABORT and NOP commands over a valid/ready handshake and produces exact write and count-enable pulse trains. Keeps a shadow copy of the value the posedge counter output holds after each pulse, so a checker or software can compare without reading the counter.

---
 rtl/counter_seq_pkg.sv | 27 ++
 rtl/counter_seq_tick.sv | 56 +++++
 rtl/counter_seq.sv | 215 +++++++++++++++++++++
 tb/tb_counter_seq.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_pkg
// Description : Shared definitions for the counter_seq command sequencer:
//               command opcode encodings and the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_seq_pkg;

    // Command opcodes carried on cmd_op
    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_RUN   = 2'd2,
        OP_ABORT = 2'd3
    } op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage : counter_seq_pkg
`default_nettype wire

// File: rtl/counter_seq_tick.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_tick
// Description : Prescaler tick generator for RUN cadence. Reloads the divisor
//               when a RUN command is accepted; while stepping it counts down
//               and raises 'tick' whenever the count is zero, then reloads.
//               With div = D a tick is issued every D+1 stepped cycles.
//               The whole module only exists when COUNTER_SEQ_PRESCALE_EN is
//               defined, so default builds contain no divider logic at all.
// Ports       : clk, rst_n (async, active-low)
//               load  - RUN accepted: capture div, restart the count
//               step  - sequencer is in RUN: advance the count
//               div   - divisor D (DIV_W bits)
//               tick  - pulse permit, combinational from the count register
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef COUNTER_SEQ_PRESCALE_EN
module counter_seq_tick #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    localparam logic [DIV_W-1:0] c_one = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;

    // The first RUN pulse is issued on acceptance itself, so the count starts
    // at D and reaches zero exactly D cycles after each pulse cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_div <= div;
            r_cnt <= div;
        end else if (step) begin
            if (r_cnt == '0) begin
                r_cnt <= r_div;
            end else begin
                r_cnt <= r_cnt - c_one;
            end
        end
    end

    assign tick = (r_cnt == '0);

endmodule : counter_seq_tick
`endif
`default_nettype wire

// File: rtl/counter_seq.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq
// Description : Command-driven sequencer generating cen/wen/dat for a
//               loadable up-counter. Accepts NOP/LOAD/RUN/ABORT over a
//               valid/ready handshake and keeps a shadow of the value the
//               counter holds after every pulse.
// Ports       : clk, rst_n (async, active-low)
//               cmd_valid/cmd_ready handshake; cmd_op, cmd_arg (LOAD value),
//               cmd_len (RUN pulse count), cmd_div (RUN cadence divisor)
//               cen, wen, dat  - counter control (registered)
//               busy, done     - status (registered)
//               shadow         - expected counter value (registered)
// Config      : COUNTER_SEQ_PRESCALE_EN - when defined, RUN pulses cen every
//               cmd_div+1 cycles via counter_seq_tick; otherwise cmd_div is
//               ignored and RUN pulses every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_seq
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 16,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [DIV_W-1:0] cmd_div,
    output logic             cen,
    output logic             wen,
    output logic [WIDTH-1:0] dat,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shadow
);

    localparam logic [LEN_W-1:0] c_len_one = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_wid_zero = '0;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] w_rem_nxt;
    logic             r_cen;
    logic             w_cen_nxt;
    logic             r_wen;
    logic             w_wen_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_busy;
    logic [WIDTH-1:0] r_dat;
    logic [WIDTH-1:0] w_dat_nxt;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] w_shadow_nxt;

    logic             w_accept;
    logic             w_tick;

    // Ready is the only combinational output. In RUN only an ABORT may be
    // taken, so a pending LOAD/RUN simply waits for IDLE.
    assign cmd_ready = rst_n & ((r_state == ST_IDLE) |
                                ((r_state == ST_RUN) & (cmd_op == OP_ABORT)));
    assign w_accept  = cmd_valid & cmd_ready;

`ifdef COUNTER_SEQ_PRESCALE_EN
    logic w_run_load;
    logic w_in_run;

    assign w_run_load = w_accept & (r_state == ST_IDLE) & (cmd_op == OP_RUN);
    assign w_in_run   = (r_state == ST_RUN);

    counter_seq_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_run_load),
        .step  (w_in_run),
        .div   (cmd_div),
        .tick  (w_tick)
    );
`else
    // No divider: every RUN cycle is a pulse cycle; cmd_div is intentionally
    // left unconnected to any logic.
    logic w_unused_div;
    assign w_unused_div = ^cmd_div;
    assign w_tick       = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // Next-state and next-output logic. Outputs are computed here one cycle
    // ahead and registered below, so every pulse lands in the cycle right
    // after the decision edge.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_rem_nxt    = r_rem;
        w_cen_nxt    = 1'b0;
        w_wen_nxt    = 1'b0;
        w_done_nxt   = 1'b0;
        w_dat_nxt    = r_dat;
        // The counter increments at the edge that ends a cen cycle, so the
        // shadow follows the registered pulse. This also covers a pulse that
        // is in flight when an ABORT is accepted.
        w_shadow_nxt = r_shadow + {c_wid_zero[WIDTH-1:1], r_cen};

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            w_state_nxt = ST_LOAD;
                            w_wen_nxt   = 1'b1;
                            w_dat_nxt   = cmd_arg;
                        end
                        OP_RUN: begin
                            if (cmd_len == '0) begin
                                w_state_nxt = ST_DONE;
                                w_done_nxt  = 1'b1;
                            end else begin
                                // First pulse is issued on acceptance; r_rem
                                // counts the pulses still to come, so it can
                                // never wrap below zero even for max length.
                                w_state_nxt = ST_RUN;
                                w_cen_nxt   = 1'b1;
                                w_rem_nxt   = cmd_len - c_len_one;
                            end
                        end
                        default: begin
                            // NOP and ABORT in IDLE are consumed silently
                        end
                    endcase
                end
            end

            ST_LOAD: begin
                // wen is high during this cycle; the counter takes dat at the
                // closing edge and so does the shadow.
                w_shadow_nxt = r_dat;
                w_state_nxt  = ST_DONE;
                w_done_nxt   = 1'b1;
            end

            ST_RUN: begin
                if (w_accept) begin
                    // Only ABORT can be accepted here: stop without done
                    w_state_nxt = ST_IDLE;
                    w_rem_nxt   = '0;
                end else if (r_rem == '0) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else if (w_tick) begin
                    w_cen_nxt = 1'b1;
                    w_rem_nxt = r_rem - c_len_one;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Registered datapath and outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem    <= '0;
            r_cen    <= 1'b0;
            r_wen    <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_dat    <= '0;
            r_shadow <= '0;
        end else begin
            r_rem    <= w_rem_nxt;
            r_cen    <= w_cen_nxt;
            r_wen    <= w_wen_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_dat    <= w_dat_nxt;
            r_shadow <= w_shadow_nxt;
        end
    end

    assign cen    = r_cen;
    assign wen    = r_wen;
    assign dat    = r_dat;
    assign busy   = r_busy;
    assign done   = r_done;
    assign shadow = r_shadow;

endmodule : counter_seq
`default_nettype wire

// File: tb/tb_counter_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_seq
// Description : Scoreboard bench for counter_seq. Each accepted command pushes
//               its expected output events (cycle, kind, value) into a queue;
//               a monitor pops and compares whenever cen/wen/done is seen.
//               Expected events come from the command rules: pulse i of a RUN
//               lands i*(D+1) cycles after acceptance, done one cycle after
//               the last pulse, shadow = start + pulses mod 256.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_seq;

    localparam int WIDTH = 8;
    localparam int LEN_W = 16;
    localparam int DIV_W = 8;

    localparam logic [1:0] K_OP_NOP   = 2'd0;
    localparam logic [1:0] K_OP_LOAD  = 2'd1;
    localparam logic [1:0] K_OP_RUN   = 2'd2;
    localparam logic [1:0] K_OP_ABORT = 2'd3;

    localparam logic [2:0] K_CEN  = 3'b001;
    localparam logic [2:0] K_WEN  = 3'b010;
    localparam logic [2:0] K_DONE = 3'b100;

`ifdef COUNTER_SEQ_PRESCALE_EN
    localparam bit PRESCALE = 1'b1;
`else
    localparam bit PRESCALE = 1'b0;
`endif

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op    = 2'd0;
    logic [WIDTH-1:0] cmd_arg   = '0;
    logic [LEN_W-1:0] cmd_len   = '0;
    logic [DIV_W-1:0] cmd_div   = '0;
    logic             cen;
    logic             wen;
    logic [WIDTH-1:0] dat;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] shadow;

    counter_seq #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W),
        .DIV_W (DIV_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .cmd_len   (cmd_len),
        .cmd_div   (cmd_div),
        .cen       (cen),
        .wen       (wen),
        .dat       (dat),
        .busy      (busy),
        .done      (done),
        .shadow    (shadow)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; a pulse set at edge k is seen
    // at the following falling edge with cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] kind;
        logic [7:0] val;
    } ev_t;

    ev_t        q[$];
    ev_t        ev;
    int         n_tests  = 0;
    int         n_fail   = 0;
    int         busy_cnt = 0;
    logic [7:0] m_shadow = 8'h00;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt <= busy_cnt + 1;
            if (cen && wen) check("cen_wen_exclusive", 32'(1), 32'(0));
            while (q.size() > 0 && q[0].cyc < cyc) begin
                check("missed_event_cycle", 32'(cyc), 32'(q[0].cyc));
                ev = q.pop_front();
            end
            if (cen || wen || done) begin
                if (q.size() == 0) begin
                    check("unexpected_output", 32'({done, wen, cen}), 32'(0));
                end else begin
                    ev = q.pop_front();
                    check("event_cycle", 32'(cyc), 32'(ev.cyc));
                    check("event_kind", 32'({done, wen, cen}), 32'(ev.kind));
                    check("event_busy", 32'(busy), 32'(1));
                    if (ev.kind == K_WEN) check("wen_dat", 32'(dat), 32'(ev.val));
                    else                  check("event_shadow", 32'(shadow), 32'(ev.val));
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic send(input logic [1:0] op, input logic [7:0] arg,
                        input logic [15:0] len, input logic [7:0] div,
                        output int k);
        int guard;
        guard = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_len   = len;
        cmd_div   = div;
        #1;
        while (!cmd_ready && guard < 500) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("cmd_ready_before_accept", 32'(cmd_ready), 32'(1));
        k = cyc + 1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = K_OP_NOP;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while ((busy || q.size() != 0) && guard < 2000);
        if (guard >= 2000) check("idle_timeout", 32'(0), 32'(1));
    endtask

    task automatic finish_cmd(input int b0, input int busy_exp);
        wait_idle();
        check("busy_cycles", 32'(busy_cnt - b0), 32'(busy_exp));
        check("idle_shadow", 32'(shadow), 32'(m_shadow));
    endtask

    task automatic do_load(input logic [7:0] arg);
        int k, b0;
        b0 = busy_cnt;
        send(K_OP_LOAD, arg, 16'd0, 8'd0, k);
        q.push_back(ev_t'{k, K_WEN, arg});
        q.push_back(ev_t'{k + 1, K_DONE, arg});
        m_shadow = arg;
        finish_cmd(b0, 2);
    endtask

    task automatic do_idle_op(input logic [1:0] op);
        int k, b0;
        b0 = busy_cnt;
        send(op, 8'($urandom), 16'($urandom_range(0, 20)), 8'($urandom), k);
        finish_cmd(b0, 0);
    endtask

    // abort_after = 0 runs to completion; otherwise ABORT is accepted at the
    // edge closing the abort_after-th pulse cycle (1 <= abort_after <= len).
    task automatic do_run(input int len, input logic [7:0] div, input int abort_after);
        int k, d, n, b0, e, done_c, guard;
        logic [7:0] s;
        d  = PRESCALE ? int'(div) : 0;
        s  = m_shadow;
        b0 = busy_cnt;
        send(K_OP_RUN, 8'd0, 16'(len), div, k);
        n = (abort_after > 0) ? abort_after : len;
        for (int i = 0; i < n; i++) q.push_back(ev_t'{k + i * (d + 1), K_CEN, 8'(int'(s) + i)});
        m_shadow = 8'(int'(s) + n);
        if (abort_after == 0) begin
            done_c = (len == 0) ? k : k + (len - 1) * (d + 1) + 1;
            q.push_back(ev_t'{done_c, K_DONE, m_shadow});
            finish_cmd(b0, done_c - k + 1);
        end else begin
            e     = k + (abort_after - 1) * (d + 1) + 1;
            guard = 0;
            while (cyc < e - 1 && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            cmd_valid = 1'b1;
            cmd_op    = K_OP_ABORT;
            #1;
            check("abort_ready", 32'(cmd_ready), 32'(1));
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            cmd_op    = K_OP_NOP;
            finish_cmd(b0, e - k);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cen"},    32'(cen),    32'(0));
        check({tag, "_wen"},    32'(wen),    32'(0));
        check({tag, "_dat"},    32'(dat),    32'(0));
        check({tag, "_busy"},   32'(busy),   32'(0));
        check({tag, "_done"},   32'(done),   32'(0));
        check({tag, "_shadow"}, 32'(shadow), 32'(0));
        check({tag, "_ready"},  32'(cmd_ready), 32'(0));
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int k, len, ab;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        #2 rst_n = 1'b1;
        #1 check("ready_after_reset", 32'(cmd_ready), 32'(1));

        do_load(8'hA5);
        check("load_dat_hold", 32'(dat), 32'(8'hA5));

        do_load(8'hFD);
        do_run(5, 8'd0, 0);
        check("wrap_shadow", 32'(shadow), 32'(8'h02));

        do_run(0, 8'd0, 0);
        do_run(10, 8'd0, 3);
        do_idle_op(K_OP_ABORT);
        do_idle_op(K_OP_NOP);

`ifdef COUNTER_SEQ_PRESCALE_EN
        do_run(3, 8'd2, 0);
        do_run(4, 8'd1, 2);
`endif
        // Ignored divisor without the prescaler, real cadence with it
        do_run(4, 8'd3, 0);

        // Reset in the middle of a RUN
        send(K_OP_RUN, 8'd0, 16'd10, 8'd0, k);
        for (int i = 0; i < 10; i++) q.push_back(ev_t'{k + i, K_CEN, 8'(int'(m_shadow) + i)});
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        m_shadow = 8'h00;
        #1 check_reset_outputs("midrun_reset");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        do_load(8'h3C);

        // Randomized command stream
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 3))
                0: do_idle_op(K_OP_NOP);
                1: do_load(8'($urandom));
                2: begin
                    len = $urandom_range(0, 12);
                    ab  = 0;
                    if (len > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, len);
                    do_run(len, 8'($urandom_range(0, 3)), ab);
                end
                default: do_idle_op(K_OP_ABORT);
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_counter_seq
`default_nettype wire
